// File: rtl/dnn_stream_dma_if.sv
// -----------------------------------------------------------------------------
// dnn_stream_dma_if
// Bundles every handshake and memory-port signal of dnn_stream_dma.
//   master : the DMA engine. It drives the busy/done status, the memory read
//            and write strobes, the src_* stream toward the accelerator and
//            dst_ready.
//   slave  : the environment (host, memories, accelerator). It drives the
//            start commands, rd_data, src_ready and the dst_* stream.
// Parameters: AW = word address width, LW = transfer length width (words).
// -----------------------------------------------------------------------------
interface dnn_stream_dma_if #(
  parameter int AW = 16,
  parameter int LW = 16
);
  // MM2S command and status
  logic          mm2s_start;
  logic [AW-1:0] mm2s_addr;
  logic [LW-1:0] mm2s_len;
  logic          mm2s_busy;
  logic          mm2s_done;
  // Memory read port
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  // Stream toward the accelerator
  logic          src_valid;
  logic [31:0]   src_data;
  logic          src_last;
  logic          src_ready;
  // S2MM command and status
  logic          s2mm_start;
  logic [AW-1:0] s2mm_addr;
  logic [LW-1:0] s2mm_len;
  logic          s2mm_busy;
  logic          s2mm_done;
  logic          s2mm_err;
  // Memory write port
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  // Stream from the accelerator
  logic          dst_valid;
  logic [31:0]   dst_data;
  logic          dst_last;
  logic          dst_ready;

  modport master (
    input  mm2s_start, mm2s_addr, mm2s_len, rd_data, src_ready,
           s2mm_start, s2mm_addr, s2mm_len, dst_valid, dst_data, dst_last,
    output mm2s_busy, mm2s_done, rd_en, rd_addr, src_valid, src_data, src_last,
           s2mm_busy, s2mm_done, s2mm_err, wr_en, wr_addr, wr_data, dst_ready
  );

  modport slave (
    output mm2s_start, mm2s_addr, mm2s_len, rd_data, src_ready,
           s2mm_start, s2mm_addr, s2mm_len, dst_valid, dst_data, dst_last,
    input  mm2s_busy, mm2s_done, rd_en, rd_addr, src_valid, src_data, src_last,
           s2mm_busy, s2mm_done, s2mm_err, wr_en, wr_addr, wr_data, dst_ready
  );
endinterface

// File: rtl/dnn_stream_dma.sv
// -----------------------------------------------------------------------------
// dnn_stream_dma
// Host-side stream engine for the MNIST accelerator. Two independent channels:
//   MM2S : reads len words from memory starting at addr and streams them out
//          on src_* (src_last on the final word). A 2-entry FIFO absorbs the
//          one-cycle read latency so the stream runs at one word per cycle and
//          stalls cleanly under src_ready backpressure.
//   S2MM : accepts words from dst_* and writes them to consecutive addresses.
//          It stops on len words or on dst_last, whichever comes first, and
//          flags s2mm_err when dst_last and the word count disagree.
// Ports:
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : dnn_stream_dma_if.master (commands, status, memory ports,
//                both streams)
// -----------------------------------------------------------------------------
module dnn_stream_dma #(
  parameter int AW = 16,
  parameter int LW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dnn_stream_dma_if.master bus
);

  // ===========================================================================
  // MM2S channel
  // ===========================================================================
  typedef enum logic [1:0] {MM2S_IDLE, MM2S_RUN, MM2S_DRAIN} mm2s_state_e;

  mm2s_state_e   r_mm2s_state, w_mm2s_next;
  logic [AW-1:0] r_mm2s_base;
  logic [LW-1:0] r_mm2s_len;
  logic [LW-1:0] r_issued;     // reads issued so far
  logic [LW-1:0] r_sent;       // words handed over on src_*
  logic          r_inflight;   // read issued last cycle, data arrives now
  logic          r_mm2s_done;
  logic [31:0]   r_fifo [2];
  logic          r_fifo_wptr, r_fifo_rptr;
  logic [1:0]    r_fifo_cnt;

  logic          w_mm2s_accept, w_mm2s_zero;
  logic          w_src_valid, w_pop, w_issue, w_last_word;
  logic [2:0]    w_occ;

  assign w_mm2s_accept = (r_mm2s_state == MM2S_IDLE) && bus.mm2s_start && (bus.mm2s_len != '0);
  assign w_mm2s_zero   = (r_mm2s_state == MM2S_IDLE) && bus.mm2s_start && (bus.mm2s_len == '0);
  assign w_src_valid   = (r_fifo_cnt != 2'd0);
  assign w_pop         = w_src_valid && bus.src_ready;
  assign w_last_word   = (r_sent == r_mm2s_len - LW'(1));

  // Occupancy the FIFO will have after this cycle if no new read is issued.
  // Using this cycle's pop lets reads resume the moment a slot frees.
  assign w_occ   = 3'(r_fifo_cnt) + 3'(r_inflight) - 3'(w_pop);
  assign w_issue = (r_mm2s_state == MM2S_RUN) && (r_issued < r_mm2s_len) && (w_occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mm2s_state <= MM2S_IDLE;
    else        r_mm2s_state <= w_mm2s_next;
  end

  // NOTE: always_comb assigns every output a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    w_mm2s_next = r_mm2s_state;
    unique case (r_mm2s_state)
      MM2S_IDLE:  if (w_mm2s_accept) w_mm2s_next = MM2S_RUN;
      MM2S_RUN:   if (w_issue && (r_issued == r_mm2s_len - LW'(1))) w_mm2s_next = MM2S_DRAIN;
      MM2S_DRAIN: if (w_pop && w_last_word) w_mm2s_next = MM2S_IDLE;
      default:    w_mm2s_next = MM2S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mm2s_base <= '0;
      r_mm2s_len  <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      r_mm2s_done <= 1'b0;
      r_inflight  <= 1'b0;
      r_fifo_wptr <= 1'b0;
      r_fifo_rptr <= 1'b0;
      r_fifo_cnt  <= 2'd0;
    end else begin
      r_mm2s_done <= w_mm2s_zero || ((r_mm2s_state == MM2S_DRAIN) && w_pop && w_last_word);
      if (w_mm2s_accept) begin
        r_mm2s_base <= bus.mm2s_addr;
        r_mm2s_len  <= bus.mm2s_len;
        r_issued    <= '0;
        r_sent      <= '0;
      end else begin
        if (w_issue) r_issued <= r_issued + LW'(1);
        if (w_pop)   r_sent   <= r_sent + LW'(1);
      end
      r_inflight <= w_issue;
      if (r_inflight) r_fifo_wptr <= ~r_fifo_wptr;
      if (w_pop)      r_fifo_rptr <= ~r_fifo_rptr;
      r_fifo_cnt <= r_fifo_cnt + 2'(r_inflight) - 2'(w_pop);
    end
  end

  // NOTE: FIFO storage has no reset; occupancy lives in r_fifo_cnt and the
  // output is gated by src_valid, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (r_inflight) r_fifo[r_fifo_wptr] <= bus.rd_data;
  end

  assign bus.mm2s_busy = (r_mm2s_state != MM2S_IDLE);
  assign bus.mm2s_done = r_mm2s_done;
  assign bus.rd_en     = w_issue;
  assign bus.rd_addr   = w_issue ? (r_mm2s_base + AW'(r_issued)) : '0;
  assign bus.src_valid = w_src_valid;
  assign bus.src_data  = w_src_valid ? r_fifo[r_fifo_rptr] : '0;
  assign bus.src_last  = w_src_valid && w_last_word;

  // ===========================================================================
  // S2MM channel
  // ===========================================================================
  typedef enum logic [1:0] {S2MM_IDLE, S2MM_RUN, S2MM_FLUSH} s2mm_state_e;

  s2mm_state_e   r_s2mm_state, w_s2mm_next;
  logic [AW-1:0] r_s2mm_base;
  logic [LW-1:0] r_s2mm_len;
  logic [LW-1:0] r_s2mm_cnt;
  logic          r_s2mm_done;
  logic          r_s2mm_err;
  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [31:0]   r_wr_data;

  logic          w_s2mm_cmd, w_s2mm_accept, w_s2mm_zero;
  logic          w_hs, w_final, w_term;

  // FLUSH already reports done with busy low, so a new command is taken there
  // just as in IDLE.
  assign w_s2mm_cmd    = (r_s2mm_state != S2MM_RUN) && bus.s2mm_start;
  assign w_s2mm_accept = w_s2mm_cmd && (bus.s2mm_len != '0);
  assign w_s2mm_zero   = w_s2mm_cmd && (bus.s2mm_len == '0);
  assign w_hs          = (r_s2mm_state == S2MM_RUN) && bus.dst_valid;
  assign w_final       = (r_s2mm_cnt == r_s2mm_len - LW'(1));
  assign w_term        = w_hs && (w_final || bus.dst_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_s2mm_state <= S2MM_IDLE;
    else        r_s2mm_state <= w_s2mm_next;
  end

  always_comb begin
    w_s2mm_next = r_s2mm_state;
    unique case (r_s2mm_state)
      S2MM_IDLE:  if (w_s2mm_accept) w_s2mm_next = S2MM_RUN;
      S2MM_RUN:   if (w_term) w_s2mm_next = S2MM_FLUSH;
      S2MM_FLUSH: w_s2mm_next = w_s2mm_accept ? S2MM_RUN : S2MM_IDLE;
      default:    w_s2mm_next = S2MM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2mm_base <= '0;
      r_s2mm_len  <= '0;
      r_s2mm_cnt  <= '0;
      r_s2mm_done <= 1'b0;
      r_s2mm_err  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      // The terminating handshake's write lands in FLUSH, together with done.
      r_s2mm_done <= w_s2mm_zero || w_term;
      r_wr_en     <= w_hs;
      if (w_s2mm_cmd) begin
        r_s2mm_err  <= 1'b0;
        r_s2mm_base <= bus.s2mm_addr;
        r_s2mm_len  <= bus.s2mm_len;
        r_s2mm_cnt  <= '0;
      end
      if (w_hs) begin
        r_wr_addr  <= r_s2mm_base + AW'(r_s2mm_cnt);
        r_wr_data  <= bus.dst_data;
        r_s2mm_cnt <= r_s2mm_cnt + LW'(1);
        // Early last, or the len-th word without last: both are mismatches.
        if (bus.dst_last != w_final) r_s2mm_err <= 1'b1;
      end
    end
  end

  assign bus.s2mm_busy = (r_s2mm_state == S2MM_RUN);
  assign bus.s2mm_done = r_s2mm_done;
  assign bus.s2mm_err  = r_s2mm_err;
  assign bus.dst_ready = (r_s2mm_state == S2MM_RUN);
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;

endmodule

// File: tb/tb_dnn_stream_dma.sv
// -----------------------------------------------------------------------------
// tb_dnn_stream_dma
// Directed sequence with randomized data, valid gaps and backpressure. The
// expected stream, write list, termination point and error flag come from a
// word memory and simple arithmetic on base/len/last position.
// -----------------------------------------------------------------------------
module tb_dnn_stream_dma;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dnn_stream_dma_if bus ();

  dnn_stream_dma dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word memory behind the read port: data one cycle after rd_en.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (observed=running expected=finished)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] wrap(input logic [15:0] b, input int off);
    return 16'(32'(b) + 32'(off));
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_mm2s_busy"}, 32'(bus.mm2s_busy), 32'd0);
    check({pfx, "_mm2s_done"}, 32'(bus.mm2s_done), 32'd0);
    check({pfx, "_rd_en"},     32'(bus.rd_en),     32'd0);
    check({pfx, "_rd_addr"},   32'(bus.rd_addr),   32'd0);
    check({pfx, "_src_valid"}, 32'(bus.src_valid), 32'd0);
    check({pfx, "_src_data"},  bus.src_data,       32'd0);
    check({pfx, "_src_last"},  32'(bus.src_last),  32'd0);
    check({pfx, "_s2mm_busy"}, 32'(bus.s2mm_busy), 32'd0);
    check({pfx, "_s2mm_done"}, 32'(bus.s2mm_done), 32'd0);
    check({pfx, "_s2mm_err"},  32'(bus.s2mm_err),  32'd0);
    check({pfx, "_wr_en"},     32'(bus.wr_en),     32'd0);
    check({pfx, "_wr_addr"},   32'(bus.wr_addr),   32'd0);
    check({pfx, "_wr_data"},   bus.wr_data,        32'd0);
    check({pfx, "_dst_ready"}, 32'(bus.dst_ready), 32'd0);
  endtask

  // MM2S transfer. mode 0: src_ready=1; 1: ready pattern 1,0,0; 2: random.
  // poke re-issues a start mid-transfer, which must be ignored.
  task automatic mm2s_xfer(input logic [15:0] base, input int len, input int mode,
                           input bit chk_lat, input bit poke);
    int   cyc = 0, issued = 0, sent = 0, done_cnt = 0, done_cyc = -1;
    int   last_hs = -1, first_valid = -1;
    bit   prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    for (int i = 0; i < len; i++) mem[wrap(base, i)] = $urandom;
    @(negedge clk);
    bus.mm2s_start = 1'b1;
    bus.mm2s_addr  = base;
    bus.mm2s_len   = 16'(len);
    bus.src_ready  = 1'b0;
    while (!(last_hs >= 0 && cyc >= last_hs + 2) && cyc < 40 * len + 40) begin
      @(negedge clk);
      cyc++;
      bus.mm2s_start = 1'b0;
      if (poke && cyc == 2) begin
        bus.mm2s_start = 1'b1;
        bus.mm2s_addr  = 16'h0ABC;
        bus.mm2s_len   = 16'd9;
      end
      case (mode)
        0:       bus.src_ready = 1'b1;
        1:       bus.src_ready = (cyc % 3 == 0);
        default: bus.src_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (bus.rd_en) begin
        check("rd_addr", 32'(bus.rd_addr), 32'(wrap(base, issued)));
        issued++;
      end
      if (prev_stall) begin
        check("stall_valid", 32'(bus.src_valid), 32'd1);
        check("stall_data",  bus.src_data,       prev_data);
        check("stall_last",  32'(bus.src_last),  32'(prev_last));
      end
      if (bus.src_valid) begin
        if (first_valid < 0) first_valid = cyc;
        check("src_data", bus.src_data,      mem[wrap(base, sent)]);
        check("src_last", 32'(bus.src_last), 32'(sent == len - 1));
        if (bus.src_ready) begin
          if (sent == len - 1) last_hs = cyc;
          sent++;
        end
      end
      check("outstanding", 32'((issued - sent) <= 2), 32'd1);
      check("mm2s_busy", 32'(bus.mm2s_busy), 32'(last_hs < 0 || cyc <= last_hs));
      if (bus.mm2s_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.src_valid && !bus.src_ready;
      prev_data  = bus.src_data;
      prev_last  = bus.src_last;
    end
    check("mm2s_words",    32'(sent),     32'(len));
    check("mm2s_reads",    32'(issued),   32'(len));
    check("mm2s_done_cnt", 32'(done_cnt), 32'd1);
    check("mm2s_done_cyc", 32'(done_cyc), 32'(last_hs + 1));
    if (chk_lat) begin
      check("mm2s_first_valid", 32'(first_valid), 32'd3);
      check("mm2s_last_hs",     32'(last_hs),     32'(3 + len - 1));
    end
    bus.src_ready = 1'b0;
  endtask

  // S2MM transfer; last_pos is the index carrying dst_last (-1: none).
  // More words than len are offered so that post-termination refusal is seen.
  task automatic s2mm_xfer(input logic [15:0] base, input int len, input int last_pos);
    logic [31:0] words[$];
    int n = len + 3;
    int cyc = 0, acc = 0, term_cyc = -1;
    int t = (last_pos >= 0 && last_pos < len - 1) ? last_pos : len - 1;
    bit exp_err = (last_pos != len - 1);
    bit prev_hs = 1'b0;
    bit exp_on;
    for (int i = 0; i < n; i++) words.push_back($urandom);
    @(negedge clk);
    bus.s2mm_start = 1'b1;
    bus.s2mm_addr  = base;
    bus.s2mm_len   = 16'(len);
    bus.dst_valid  = 1'b0;
    while (!(term_cyc >= 0 && cyc >= term_cyc + 3) && cyc < 40 * len + 40) begin
      @(negedge clk);
      cyc++;
      bus.s2mm_start = 1'b0;
      bus.dst_valid  = (acc < n) && ($urandom_range(0, 3) != 0);
      bus.dst_data   = (acc < n) ? words[acc] : 32'd0;
      bus.dst_last   = bus.dst_valid && (acc == last_pos);
      #1;
      exp_on = (term_cyc < 0);
      check("dst_ready", 32'(bus.dst_ready), 32'(exp_on));
      check("s2mm_busy", 32'(bus.s2mm_busy), 32'(exp_on));
      if (cyc == 1) check("s2mm_err_clear", 32'(bus.s2mm_err), 32'd0);
      check("wr_en", 32'(bus.wr_en), 32'(prev_hs));
      if (prev_hs) begin
        check("wr_addr", 32'(bus.wr_addr), 32'(wrap(base, acc - 1)));
        check("wr_data", bus.wr_data,      words[acc - 1]);
      end
      check("s2mm_done", 32'(bus.s2mm_done), 32'(term_cyc >= 0 && cyc == term_cyc + 1));
      prev_hs = bus.dst_valid && bus.dst_ready;
      if (prev_hs) begin
        if (acc == t) term_cyc = cyc;
        acc++;
      end
    end
    check("s2mm_accepted", 32'(acc),          32'(t + 1));
    check("s2mm_err",      32'(bus.s2mm_err), 32'(exp_err));
    bus.dst_valid = 1'b0;
    bus.dst_last  = 1'b0;
  endtask

  initial begin
    int sent;
    rst_n          = 1'b0;
    bus.mm2s_start = 1'b0;
    bus.mm2s_addr  = '0;
    bus.mm2s_len   = '0;
    bus.src_ready  = 1'b0;
    bus.s2mm_start = 1'b0;
    bus.s2mm_addr  = '0;
    bus.s2mm_len   = '0;
    bus.dst_valid  = 1'b0;
    bus.dst_data   = '0;
    bus.dst_last   = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // MM2S: plain, backpressured, random, ignored restart, address wrap.
    mm2s_xfer(16'h0010, 4, 0, 1'b1, 1'b0);
    mm2s_xfer(16'h0200, 6, 1, 1'b0, 1'b0);
    mm2s_xfer(16'($urandom), 7, 2, 1'b0, 1'b0);
    mm2s_xfer(16'h0300, 5, 0, 1'b1, 1'b1);
    mm2s_xfer(16'hFFFE, 4, 0, 1'b1, 1'b0);

    // S2MM: normal, early last, missing last.
    s2mm_xfer(16'h0100, 3, 2);
    s2mm_xfer(16'h0400, 5, 1);
    s2mm_xfer(16'h0500, 2, -1);

    // len=0 on both channels at once; the new start also clears s2mm_err.
    @(negedge clk);
    bus.mm2s_start = 1'b1;
    bus.mm2s_len   = '0;
    bus.s2mm_start = 1'b1;
    bus.s2mm_len   = '0;
    @(negedge clk);
    bus.mm2s_start = 1'b0;
    bus.s2mm_start = 1'b0;
    #1;
    check("zero_mm2s_done", 32'(bus.mm2s_done), 32'd1);
    check("zero_s2mm_done", 32'(bus.s2mm_done), 32'd1);
    check("zero_mm2s_busy", 32'(bus.mm2s_busy), 32'd0);
    check("zero_s2mm_busy", 32'(bus.s2mm_busy), 32'd0);
    check("zero_dst_ready", 32'(bus.dst_ready), 32'd0);
    check("zero_rd_en",     32'(bus.rd_en),     32'd0);
    check("zero_err_clear", 32'(bus.s2mm_err),  32'd0);
    @(negedge clk);
    #1;
    check("zero_mm2s_done_end", 32'(bus.mm2s_done), 32'd0);
    check("zero_s2mm_done_end", 32'(bus.s2mm_done), 32'd0);
    check("zero_dst_ready_end", 32'(bus.dst_ready), 32'd0);

    // S2MM with address wrap and random data.
    s2mm_xfer(16'hFFFF, 3, 2);

    // Reset in the middle of an MM2S transfer, then a fresh transfer.
    for (int i = 0; i < 6; i++) mem[wrap(16'h0040, i)] = $urandom;
    @(negedge clk);
    bus.mm2s_start = 1'b1;
    bus.mm2s_addr  = 16'h0040;
    bus.mm2s_len   = 16'd6;
    bus.src_ready  = 1'b1;
    sent = 0;
    for (int c = 0; c < 20 && sent < 2; c++) begin
      @(negedge clk);
      bus.mm2s_start = 1'b0;
      #1;
      if (bus.src_valid) begin
        check("rst_pre_data", bus.src_data, mem[wrap(16'h0040, sent)]);
        sent++;
      end
    end
    check("rst_pre_words", 32'(sent), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check("midrst_no_done", 32'(bus.mm2s_done), 32'd0);
      check("midrst_no_busy", 32'(bus.mm2s_busy), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.src_ready = 1'b0;
    mm2s_xfer(16'h0080, 2, 0, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
